// File: rtl/offchip_mem_pkg.sv
// Shared types and helpers for the off-chip memory model.
package offchip_mem_pkg;

  // Widest channel data path the mask helper can describe.
  localparam int unsigned MAX_DATA_W = 64;

  // What a channel is asking for in the current cycle.
  typedef enum logic [1:0] {
    REQ_IDLE,
    REQ_READ,
    REQ_WRITE,
    REQ_BOTH
  } req_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) res++;
    return res;
  endfunction

  // Low 'size' bits set, clipped to the channel data width.
  function automatic logic [MAX_DATA_W-1:0] size_to_mask(input int unsigned size,
                                                          input int unsigned data_w);
    logic [MAX_DATA_W-1:0] lim;
    logic [MAX_DATA_W-1:0] m;
    lim = (data_w >= MAX_DATA_W) ? '1 : ((64'd1 << data_w) - 64'd1);
    m   = (size   >= MAX_DATA_W) ? '1 : ((64'd1 << size)   - 64'd1);
    return m & lim;
  endfunction

endpackage

// File: rtl/offchip_mem_if.sv
// Request/return bus between HLS master ports and the memory model.
interface offchip_mem_if #(
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 16,
  parameter int SIZE_W   = 5
);
  logic [CHANNELS-1:0]        m_oe;
  logic [CHANNELS-1:0]        m_we;
  logic [CHANNELS*ADDR_W-1:0] m_addr;
  logic [CHANNELS*DATA_W-1:0] m_wdata;
  logic [CHANNELS*SIZE_W-1:0] m_size;
  logic [CHANNELS*DATA_W-1:0] s_rdata;
  logic [CHANNELS-1:0]        s_rdy;
  logic [CHANNELS*DATA_W-1:0] m_rdata;
  logic [CHANNELS-1:0]        m_rdy;

  // Requesting side: issues accesses and supplies the chained slave return.
  modport master (output m_oe, m_we, m_addr, m_wdata, m_size, s_rdata, s_rdy,
                  input  m_rdata, m_rdy);

  // Memory side: serves accesses and merges the chained slave return.
  modport slave  (input  m_oe, m_we, m_addr, m_wdata, m_size, s_rdata, s_rdy,
                  output m_rdata, m_rdy);
endinterface

// File: rtl/offchip_mem_port.sv
// One channel: window hit decode, latency counter and completion pulse.
module offchip_mem_port
  import offchip_mem_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int MEMSIZE = 32,
  parameter int RD_LAT  = 2,
  parameter int WR_LAT  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              oe_i,
  input  logic              we_i,
  output req_e              req_o,
  output logic [ADDR_W-1:0] offset_o,
  output logic              done_o
);

  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] count_q, count_d, last_cnt;
  logic             hit, active;

  // Decode the request, then advance the counter while a hit is held.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the block infers a latch.
    req_o    = REQ_IDLE;
    offset_o = addr_i - base_addr_i;
    hit      = 1'b0;
    active   = 1'b0;
    last_cnt = '0;
    done_o   = 1'b0;
    count_d  = '0;

    case ({oe_i, we_i})
      2'b10:   req_o = REQ_READ;
      2'b01:   req_o = REQ_WRITE;
      2'b11:   req_o = REQ_BOTH;
      default: req_o = REQ_IDLE;
    endcase

    hit      = (addr_i >= base_addr_i) && (32'(offset_o) < 32'(MEMSIZE));
    // oe and we together is a protocol error; the channel stays idle.
    active   = hit && (req_o == REQ_READ || req_o == REQ_WRITE);
    last_cnt = (req_o == REQ_READ) ? CNT_W'(RD_LAT - 1) : CNT_W'(WR_LAT - 1);
    // Reset suppresses completion so an in-flight access is simply dropped.
    done_o   = active && !reset && (count_q == last_cnt);
    if (active && !done_o) count_d = count_q + 1'b1;
  end

  // Latency counter register; a dropped request or completion returns it to 0.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/offchip_mem_model.sv
// N-channel byte-addressed external memory model with preload and error flags.
module offchip_mem_model
  import offchip_mem_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 16,
  parameter int SIZE_W   = 5,
  parameter int MEMSIZE  = 32,
  parameter int RD_LAT   = 2,
  parameter int WR_LAT   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] base_addr,
  offchip_mem_if.slave      bus,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_byte,
  output logic              err_both,
  output logic              err_collide
);

  localparam int LANES = DATA_W / 8;
  localparam int IDX_W = (MEMSIZE > 1) ? clog2(MEMSIZE) : 1;

  req_e              req    [CHANNELS];
  logic [ADDR_W-1:0] offset [CHANNELS];
  logic [DATA_W-1:0] mask   [CHANNELS];
  logic [CHANNELS-1:0] done;

  logic [7:0]         mem_q [MEMSIZE];
  logic [7:0]         mem_d [MEMSIZE];
  logic [MEMSIZE-1:0] wr_seen;
  logic               collide;
  logic [31:0]        wr_idx, rd_idx;
  logic [7:0]         wr_lane_mask;
  logic [DATA_W-1:0]  rd_lane;
  logic               err_both_q, err_collide_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_port
    offchip_mem_port #(
      .ADDR_W (ADDR_W),
      .MEMSIZE(MEMSIZE),
      .RD_LAT (RD_LAT),
      .WR_LAT (WR_LAT)
    ) u_port (
      .clock      (clock),
      .reset      (reset),
      .base_addr_i(base_addr),
      .addr_i     (bus.m_addr[c*ADDR_W +: ADDR_W]),
      .oe_i       (bus.m_oe[c]),
      .we_i       (bus.m_we[c]),
      .req_o      (req[c]),
      .offset_o   (offset[c]),
      .done_o     (done[c])
    );
  end

  // Per-channel bit mask from the size field.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++)
      mask[c] = DATA_W'(size_to_mask(32'(bus.m_size[c*SIZE_W +: SIZE_W]), DATA_W));
  end

  // Next array image: channel writes in index order (highest wins), then preload on top.
  always_comb begin
    mem_d        = mem_q;
    wr_seen      = '0;
    collide      = 1'b0;
    wr_idx       = '0;
    wr_lane_mask = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int k = 0; k < LANES; k++) begin
        wr_idx       = 32'(offset[c]) + 32'(k);
        wr_lane_mask = mask[c][8*k +: 8];
        if (req[c] == REQ_WRITE && done[c] && wr_idx < 32'(MEMSIZE) && wr_lane_mask != 8'h00) begin
          if (wr_seen[IDX_W'(wr_idx)]) collide = 1'b1;
          wr_seen[IDX_W'(wr_idx)] = 1'b1;
          mem_d[IDX_W'(wr_idx)]   = (mem_d[IDX_W'(wr_idx)] & ~wr_lane_mask)
                                  | (bus.m_wdata[c*DATA_W + 8*k +: 8] & wr_lane_mask);
        end
      end
    end
    if (load_en && 32'(load_addr) < 32'(MEMSIZE))
      mem_d[IDX_W'(load_addr)] = load_byte;
  end

  // Byte array register; writes land at the edge ending the completion cycle.
  always_ff @(posedge clock) begin
    // NOTE: the array has no reset on purpose; contents survive reset like real memory.
    mem_q <= mem_d;
  end

  // Return path: array bytes only in the completion cycle, always OR'd with the slave side.
  always_comb begin
    rd_idx      = '0;
    rd_lane     = '0;
    bus.m_rdata = bus.s_rdata;
    for (int c = 0; c < CHANNELS; c++) begin
      rd_lane = '0;
      if (req[c] == REQ_READ && done[c]) begin
        for (int k = 0; k < LANES; k++) begin
          rd_idx = 32'(offset[c]) + 32'(k);
          if (rd_idx < 32'(MEMSIZE)) rd_lane[8*k +: 8] = mem_q[IDX_W'(rd_idx)];
        end
      end
      bus.m_rdata[c*DATA_W +: DATA_W] = bus.s_rdata[c*DATA_W +: DATA_W] | (rd_lane & mask[c]);
    end
    bus.m_rdy = bus.s_rdy | done;
  end

  // Sticky protocol-error flags, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_both_q    <= 1'b0;
      err_collide_q <= 1'b0;
    end else begin
      err_both_q    <= err_both_q | (|(bus.m_oe & bus.m_we));
      err_collide_q <= err_collide_q | collide;
    end
  end

  assign err_both    = err_both_q;
  assign err_collide = err_collide_q;

endmodule

// File: tb/tb_offchip_mem_model.sv
// Directed bench: default-latency instance plus an RD_LAT=3/WR_LAT=2 instance.
module tb_offchip_mem_model;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] base_addr;
  logic       load_en;
  logic [6:0] load_addr;
  logic [7:0] load_byte;
  logic       err_both0, err_collide0, err_both3, err_collide3;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clock = ~clock;

  offchip_mem_if #(.CHANNELS(2), .ADDR_W(7), .DATA_W(16), .SIZE_W(5)) bus0 ();
  offchip_mem_if #(.CHANNELS(2), .ADDR_W(7), .DATA_W(16), .SIZE_W(5)) bus3 ();

  offchip_mem_model #(.RD_LAT(2), .WR_LAT(1)) u_dut (
    .clock      (clock),
    .reset      (reset),
    .base_addr  (base_addr),
    .bus        (bus0.slave),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_byte  (load_byte),
    .err_both   (err_both0),
    .err_collide(err_collide0)
  );

  offchip_mem_model #(.RD_LAT(3), .WR_LAT(2)) u_dut3 (
    .clock      (clock),
    .reset      (reset),
    .base_addr  (base_addr),
    .bus        (bus3.slave),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_byte  (load_byte),
    .err_both   (err_both3),
    .err_collide(err_collide3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int which);
    if (which == 0) begin
      bus0.m_oe = '0; bus0.m_we = '0; bus0.m_addr = '0; bus0.m_wdata = '0;
      bus0.m_size = '0; bus0.s_rdata = '0; bus0.s_rdy = '0;
    end else begin
      bus3.m_oe = '0; bus3.m_we = '0; bus3.m_addr = '0; bus3.m_wdata = '0;
      bus3.m_size = '0; bus3.s_rdata = '0; bus3.s_rdy = '0;
    end
  endtask

  task automatic req(input int which, input int ch, input logic oe, input logic we,
                     input logic [6:0] addr, input logic [15:0] wd, input logic [4:0] sz);
    if (which == 0) begin
      bus0.m_oe[ch] = oe; bus0.m_we[ch] = we; bus0.m_addr[ch*7 +: 7] = addr;
      bus0.m_wdata[ch*16 +: 16] = wd; bus0.m_size[ch*5 +: 5] = sz;
    end else begin
      bus3.m_oe[ch] = oe; bus3.m_we[ch] = we; bus3.m_addr[ch*7 +: 7] = addr;
      bus3.m_wdata[ch*16 +: 16] = wd; bus3.m_size[ch*5 +: 5] = sz;
    end
  endtask

  function automatic logic [1:0] rdy(input int which);
    return (which == 0) ? bus0.m_rdy : bus3.m_rdy;
  endfunction

  function automatic logic [15:0] rdat(input int which, input int ch);
    return (which == 0) ? bus0.m_rdata[ch*16 +: 16] : bus3.m_rdata[ch*16 +: 16];
  endfunction

  // Channel-0 read held until completion; checks latency and data.
  task automatic rd_check(input int which, input logic [6:0] addr, input logic [4:0] sz,
                          input logic [15:0] exp, input string tag);
    int lat;
    lat = (which == 0) ? 2 : 3;
    idle(which);
    req(which, 0, 1'b1, 1'b0, addr, 16'h0, sz);
    #1;
    for (int i = 1; i < lat; i++) begin
      check({tag, " early"}, 32'(rdy(which)), 32'h0);
      tick();
    end
    check({tag, " rdy"}, 32'(rdy(which)), 32'h1);
    check(tag, 32'(rdat(which, 0)), 32'(exp));
    tick();
    idle(which);
  endtask

  initial begin
    reset = 1'b1; base_addr = 7'h10; load_en = 1'b0; load_addr = '0; load_byte = '0;
    idle(0); idle(3);
    tick(); tick();

    check("reset rdy", 32'(bus0.m_rdy), 32'h0);
    check("reset rdata", bus0.m_rdata, 32'h0);
    check("reset err_both", 32'(err_both0), 32'h0);
    check("reset err_collide", 32'(err_collide0), 32'h0);

    // Held hit during reset: m_rdy/m_rdata follow the slave side only.
    req(0, 0, 1'b1, 1'b0, 7'h12, 16'h0, 5'd16);
    bus0.s_rdy = 2'b10; bus0.s_rdata = 32'hABCD_0000;
    #1;
    check("reset passthru rdy c1", 32'(bus0.m_rdy), 32'h2);
    tick();
    check("reset passthru rdy c2", 32'(bus0.m_rdy), 32'h2);
    check("reset passthru rdata", bus0.m_rdata, 32'hABCD_0000);
    reset = 1'b0;
    idle(0);

    for (int i = 0; i < 32; i++) begin
      load_en = 1'b1; load_addr = 7'(i); load_byte = 8'(8'h20 + i);
      tick();
    end
    load_en = 1'b0;

    rd_check(0, 7'h12, 5'd16, 16'h2322, "rd 0x12");

    req(0, 1, 1'b0, 1'b1, 7'h14, 16'hBEEF, 5'd8);
    #1;
    check("wr lat1 rdy", 32'(bus0.m_rdy), 32'h2);
    tick(); idle(0);
    rd_check(0, 7'h14, 5'd16, 16'h25EF, "rd after wr");

    rd_check(0, 7'h12, 5'd12, 16'h0322, "size12 mask");
    rd_check(0, 7'h2F, 5'd16, 16'h003F, "rd window edge");
    rd_check(0, 7'h12, 5'd0, 16'h0000, "size0");

    // Miss: slave return only, counter must not advance.
    req(0, 0, 1'b1, 1'b0, 7'h05, 16'h0, 5'd16);
    bus0.s_rdy = 2'b01; bus0.s_rdata = 32'h0000_1234;
    #1;
    check("miss rdy", 32'(bus0.m_rdy), 32'h1);
    check("miss rdata", bus0.m_rdata, 32'h0000_1234);
    tick();
    bus0.s_rdy = '0; bus0.s_rdata = '0;
    #1;
    check("miss no count", 32'(bus0.m_rdy), 32'h0);
    tick(); idle(0);

    req(0, 0, 1'b0, 1'b1, 7'h18, 16'h0011, 5'd8);
    req(0, 1, 1'b0, 1'b1, 7'h18, 16'h0022, 5'd8);
    #1;
    check("collide rdy", 32'(bus0.m_rdy), 32'h3);
    check("collide flag before", 32'(err_collide0), 32'h0);
    tick(); idle(0);
    check("collide flag", 32'(err_collide0), 32'h1);
    rd_check(0, 7'h18, 5'd8, 16'h0022, "collide winner");
    check("collide sticky", 32'(err_collide0), 32'h1);

    // oe&we on ch0 while ch1 reads normally.
    req(0, 0, 1'b1, 1'b1, 7'h12, 16'h5555, 5'd16);
    req(0, 1, 1'b1, 1'b0, 7'h16, 16'h0, 5'd16);
    #1;
    check("both c1 rdy", 32'(bus0.m_rdy), 32'h0);
    tick();
    check("both c2 rdy", 32'(bus0.m_rdy), 32'h2);
    check("both ch1 data", 32'(rdat(0, 1)), 32'h2726);
    check("err_both", 32'(err_both0), 32'h1);
    tick(); idle(0);
    rd_check(0, 7'h12, 5'd16, 16'h2322, "both no write");

    req(0, 1, 1'b0, 1'b1, 7'h1A, 16'hFABC, 5'd12);
    tick(); idle(0);
    rd_check(0, 7'h1A, 5'd16, 16'h2ABC, "partial byte wr");

    req(0, 1, 1'b0, 1'b1, 7'h2F, 16'h5566, 5'd16);
    tick(); idle(0);
    rd_check(0, 7'h2F, 5'd16, 16'h0066, "wr edge drop");

    // Read completes in the same cycle a write hits the same byte.
    req(0, 0, 1'b1, 1'b0, 7'h1C, 16'h0, 5'd8);
    tick();
    req(0, 1, 1'b0, 1'b1, 7'h1C, 16'h00C3, 5'd8);
    #1;
    check("rw rdy", 32'(bus0.m_rdy), 32'h3);
    check("rw old value", 32'(rdat(0, 0)), 32'h002C);
    tick(); idle(0);
    rd_check(0, 7'h1C, 5'd8, 16'h00C3, "rw new value");

    req(0, 1, 1'b0, 1'b1, 7'h1D, 16'h0099, 5'd8);
    load_en = 1'b1; load_addr = 7'h0D; load_byte = 8'h77;
    tick();
    load_en = 1'b0; idle(0);
    rd_check(0, 7'h1D, 5'd8, 16'h0077, "load priority");

    // Back-to-back reads from one held request.
    req(0, 0, 1'b1, 1'b0, 7'h12, 16'h0, 5'd16);
    #1;
    check("b2b c1", 32'(bus0.m_rdy), 32'h0);
    tick(); check("b2b c2", 32'(bus0.m_rdy), 32'h1);
    tick(); check("b2b c3", 32'(bus0.m_rdy), 32'h0);
    tick(); check("b2b c4", 32'(bus0.m_rdy), 32'h1);
    tick(); idle(0);

    // RD_LAT=3: abort after one cycle, then a full-latency re-request.
    req(3, 0, 1'b1, 1'b0, 7'h12, 16'h0, 5'd16);
    #1;
    check("abort c1", 32'(bus3.m_rdy), 32'h0);
    tick(); idle(3);
    #1;
    check("abort dropped", 32'(bus3.m_rdy), 32'h0);
    tick();
    rd_check(3, 7'h12, 5'd16, 16'h2322, "rerequest");

    // WR_LAT=2 write interrupted by reset in its completion cycle.
    req(3, 0, 1'b0, 1'b1, 7'h11, 16'h00AA, 5'd8);
    #1;
    check("rst wr c1", 32'(bus3.m_rdy), 32'h0);
    tick();
    reset = 1'b1;
    #1;
    check("rst wr c2", 32'(bus3.m_rdy), 32'h0);
    tick();
    reset = 1'b0; idle(3);
    check("rst clears collide", 32'(err_collide0), 32'h0);
    check("rst clears both", 32'(err_both0), 32'h0);
    rd_check(3, 7'h11, 5'd8, 16'h0021, "reset no write");
    rd_check(0, 7'h18, 5'd8, 16'h0022, "mem kept over reset");

    req(3, 0, 1'b0, 1'b1, 7'h11, 16'h00AA, 5'd8);
    #1;
    check("wr lat2 c1", 32'(bus3.m_rdy), 32'h0);
    tick();
    check("wr lat2 c2", 32'(bus3.m_rdy), 32'h1);
    tick(); idle(3);
    rd_check(3, 7'h11, 5'd8, 16'h00AA, "wr lat2 data");
    check("dut3 no errors", 32'({err_both3, err_collide3}), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
